// File: rtl/if_id_stage_reg.sv
// if_id_stage_reg: IF/ID pipeline boundary register.
// Carries LANES instruction slots, the bundle PC and per-lane valid bits.
// Upstream is the fetch unit; downstream is the decoder.
// A main entry drives the outputs and a skid entry absorbs one extra bundle,
// so in_ready_o comes straight from a flop and never from out_ready_i.
// Lanes whose valid bit is low are stored as zero (per-lane NOP bubble).
// Bundles with no valid lane are dropped without any state change.
// Optional feature macro: IF_ID_PERF_EN adds the stall_cycles_o and
// flush_count_o saturating 16-bit performance counters.

module if_id_stage_reg #(
    parameter int LANES   = 2,
    parameter int INSTR_W = 32,
    parameter int PC_W    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [PC_W-1:0]          in_pc_i,
    input  logic [LANES*INSTR_W-1:0] in_instr_i,
    input  logic [LANES-1:0]         in_lane_valid_i,
    input  logic                     flush_i,
    input  logic                     stall_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [PC_W-1:0]          out_pc_o,
    output logic [LANES*INSTR_W-1:0] out_instr_o,
    output logic [LANES-1:0]         out_lane_valid_o
`ifdef IF_ID_PERF_EN
    ,
    output logic [15:0]              stall_cycles_o,
    output logic [15:0]              flush_count_o
`endif
);

    localparam int DW = LANES * INSTR_W;

    // Occupancy: EMPTY (no entry), ONE (main only), FULL (main + skid).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_e;

    // Zero every instruction slot whose lane-valid bit is clear.
    function automatic logic [DW-1:0] mask_lanes(
        input logic [DW-1:0]    instr,
        input logic [LANES-1:0] lane_valid
    );
        logic [DW-1:0] res;
        res = {DW{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            if (lane_valid[k]) begin
                res[k*INSTR_W +: INSTR_W] = instr[k*INSTR_W +: INSTR_W];
            end else begin
                res[k*INSTR_W +: INSTR_W] = {INSTR_W{1'b0}};
            end
        end
        return res;
    endfunction

    state_e            state_q,      state_d;
    logic              out_valid_q,  out_valid_d;
    logic              in_ready_q,   in_ready_d;
    logic [PC_W-1:0]   main_pc_q,    main_pc_d;
    logic [DW-1:0]     main_instr_q, main_instr_d;
    logic [LANES-1:0]  main_lv_q,    main_lv_d;
    logic [PC_W-1:0]   skid_pc_q,    skid_pc_d;
    logic [DW-1:0]     skid_instr_q, skid_instr_d;
    logic [LANES-1:0]  skid_lv_q,    skid_lv_d;

    logic              push_s;
    logic              pop_s;
    logic [DW-1:0]     in_instr_masked_s;

    // Handshake events; an all-bubble bundle never counts as a push.
    always_comb begin
        push_s            = in_valid_i & in_ready_q & (|in_lane_valid_i);
        pop_s             = out_valid_q & out_ready_i & ~stall_i;
        in_instr_masked_s = mask_lanes(in_instr_i, in_lane_valid_i);
    end

    // Next-state for occupancy and both entries; flush clears everything.
    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        main_lv_d    = main_lv_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        skid_lv_d    = skid_lv_q;
        if (flush_i) begin
            state_d      = ST_EMPTY;
            main_pc_d    = {PC_W{1'b0}};
            main_instr_d = {DW{1'b0}};
            main_lv_d    = {LANES{1'b0}};
            skid_pc_d    = {PC_W{1'b0}};
            skid_instr_d = {DW{1'b0}};
            skid_lv_d    = {LANES{1'b0}};
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_d      = ST_ONE;
                        main_pc_d    = in_pc_i;
                        main_instr_d = in_instr_masked_s;
                        main_lv_d    = in_lane_valid_i;
                    end else begin
                        state_d      = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        state_d      = ST_ONE;
                        main_pc_d    = in_pc_i;
                        main_instr_d = in_instr_masked_s;
                        main_lv_d    = in_lane_valid_i;
                    end else if (push_s) begin
                        state_d      = ST_FULL;
                        skid_pc_d    = in_pc_i;
                        skid_instr_d = in_instr_masked_s;
                        skid_lv_d    = in_lane_valid_i;
                    end else if (pop_s) begin
                        // Clear main so the outputs read as zero when empty.
                        state_d      = ST_EMPTY;
                        main_pc_d    = {PC_W{1'b0}};
                        main_instr_d = {DW{1'b0}};
                        main_lv_d    = {LANES{1'b0}};
                    end else begin
                        state_d      = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (pop_s) begin
                        state_d      = ST_ONE;
                        main_pc_d    = skid_pc_q;
                        main_instr_d = skid_instr_q;
                        main_lv_d    = skid_lv_q;
                        skid_pc_d    = {PC_W{1'b0}};
                        skid_instr_d = {DW{1'b0}};
                        skid_lv_d    = {LANES{1'b0}};
                    end else begin
                        state_d      = ST_FULL;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty stage.
                    state_d      = ST_EMPTY;
                    main_pc_d    = {PC_W{1'b0}};
                    main_instr_d = {DW{1'b0}};
                    main_lv_d    = {LANES{1'b0}};
                    skid_pc_d    = {PC_W{1'b0}};
                    skid_instr_d = {DW{1'b0}};
                    skid_lv_d    = {LANES{1'b0}};
                end
            endcase
        end
    end

    // Flag decode of the next occupancy so both handshake outputs are flops.
    always_comb begin
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    // State and entry registers; synchronous reset behaves like a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            main_pc_q    <= {PC_W{1'b0}};
            main_instr_q <= {DW{1'b0}};
            main_lv_q    <= {LANES{1'b0}};
            skid_pc_q    <= {PC_W{1'b0}};
            skid_instr_q <= {DW{1'b0}};
            skid_lv_q    <= {LANES{1'b0}};
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            main_lv_q    <= main_lv_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_lv_q    <= skid_lv_d;
        end
    end

    // Outputs come straight from the main entry; it is all-zero when empty.
    always_comb begin
        in_ready_o       = in_ready_q;
        out_valid_o      = out_valid_q;
        out_pc_o         = main_pc_q;
        out_instr_o      = main_instr_q;
        out_lane_valid_o = main_lv_q;
    end

`ifdef IF_ID_PERF_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q,  flush_count_d;

    // Saturating counters: stalled-with-valid cycles and flush cycles.
    always_comb begin
        if (out_valid_q && stall_i && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
        if (flush_i && (flush_count_q != 16'hFFFF)) begin
            flush_count_d = flush_count_q + 16'd1;
        end else begin
            flush_count_d = flush_count_q;
        end
    end

    // Counter registers; only reset clears them, flush does not.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= 16'd0;
            flush_count_q  <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    // Counter outputs are the registers themselves.
    always_comb begin
        stall_cycles_o = stall_cycles_q;
        flush_count_o  = flush_count_q;
    end
`endif

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Testbench for if_id_stage_reg: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_if_id_stage_reg;

    localparam int LANES   = 2;
    localparam int INSTR_W = 32;
    localparam int PC_W    = 8;
    localparam int DW      = LANES * INSTR_W;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [DW-1:0]     in_instr;
    logic [LANES-1:0]  in_lv;
    logic              flush;
    logic              stall;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [DW-1:0]     out_instr;
    logic [LANES-1:0]  out_lv;
`ifdef IF_ID_PERF_EN
    logic [15:0]       stall_cycles;
    logic [15:0]       flush_count;
    int unsigned       m_stall_cycles;
    int unsigned       m_flush_count;
`endif

    if_id_stage_reg #(.LANES(LANES), .INSTR_W(INSTR_W), .PC_W(PC_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .in_pc_i          (in_pc),
        .in_instr_i       (in_instr),
        .in_lane_valid_i  (in_lv),
        .flush_i          (flush),
        .stall_i          (stall),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_pc_o         (out_pc),
        .out_instr_o      (out_instr),
        .out_lane_valid_o (out_lv)
`ifdef IF_ID_PERF_EN
        ,
        .stall_cycles_o   (stall_cycles),
        .flush_count_o    (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0]  pc;
        logic [DW-1:0]    instr;
        logic [LANES-1:0] lv;
    } bundle_t;

    bundle_t q[$];
    int      checks = 0;
    int      errors = 0;
    bit      chk_en = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of at most two bundles; bubble lanes read as zero.
    task automatic model_update();
        bit      push;
        bit      pop;
        bundle_t b;
        push = in_valid && (q.size() < 2) && (in_lv != '0);
        pop  = (q.size() > 0) && out_ready && !stall;
`ifdef IF_ID_PERF_EN
        if (reset) begin
            m_stall_cycles = 0;
            m_flush_count  = 0;
        end else begin
            if ((q.size() > 0) && stall && m_stall_cycles < 65535) m_stall_cycles++;
            if (flush && m_flush_count < 65535) m_flush_count++;
        end
`endif
        if (reset || flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                b.pc    = in_pc;
                b.lv    = in_lv;
                b.instr = '0;
                for (int k = 0; k < LANES; k++)
                    if (in_lv[k]) b.instr[k*INSTR_W +: INSTR_W] = in_instr[k*INSTR_W +: INSTR_W];
                q.push_back(b);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
            chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
            if (q.size() > 0) begin
                chk("out_pc", 128'(out_pc), 128'(q[0].pc));
                chk("out_instr", 128'(out_instr), 128'(q[0].instr));
                chk("out_lv", 128'(out_lv), 128'(q[0].lv));
            end else begin
                chk("out_pc_zero", 128'(out_pc), 128'd0);
                chk("out_instr_zero", 128'(out_instr), 128'd0);
                chk("out_lv_zero", 128'(out_lv), 128'd0);
            end
`ifdef IF_ID_PERF_EN
            chk("stall_cycles", 128'(stall_cycles), 128'(m_stall_cycles));
            chk("flush_count", 128'(flush_count), 128'(m_flush_count));
`endif
        end
    end

    task automatic offer(input logic [PC_W-1:0] pc, input logic [DW-1:0] ins, input logic [LANES-1:0] lv);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = ins;
        in_lv    = lv;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; in_lv = '0;
        flush = 1'b0; stall = 1'b0; out_ready = 1'b0;
`ifdef IF_ID_PERF_EN
        m_stall_cycles = 0;
        m_flush_count  = 0;
`endif
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_pc", 128'(out_pc), 128'd0);

        // Single bundle, one-cycle latency, then pop.
        offer(8'h10, 64'h0000000B_0000000A, 2'b11);
        tick();
        in_valid = 1'b0;
        chk("single_valid", 128'(out_valid), 128'd1);
        chk("single_pc", 128'(out_pc), 128'h10);
        chk("single_instr", 128'(out_instr), 128'h0000000B_0000000A);
        out_ready = 1'b1;
        tick();
        chk("single_popped", 128'(out_valid), 128'd0);

        // Backpressure: two accepted, third waits, all leave in order.
        out_ready = 1'b0;
        offer(8'd1, 64'h11, 2'b11); tick();
        offer(8'd2, 64'h22, 2'b11); tick();
        chk("bp_in_ready_full", 128'(in_ready), 128'd0);
        offer(8'd3, 64'h33, 2'b11); tick();
        chk("bp_hold_pc1", 128'(out_pc), 128'd1);
        chk("bp_still_full", 128'(in_ready), 128'd0);
        out_ready = 1'b1; tick();
        chk("bp_pc2", 128'(out_pc), 128'd2);
        chk("bp_ready_again", 128'(in_ready), 128'd1);
        tick();
        chk("bp_pc3", 128'(out_pc), 128'd3);
        in_valid = 1'b0; tick();
        chk("bp_drained", 128'(out_valid), 128'd0);

        // Stall while full: outputs frozen for five cycles.
        out_ready = 1'b0;
        offer(8'd4, 64'h44, 2'b11); tick();
        offer(8'd5, 64'h55, 2'b11); tick();
        in_valid = 1'b0;
        stall = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_pc", 128'(out_pc), 128'd4);
            chk("stall_valid", 128'(out_valid), 128'd1);
        end
`ifdef IF_ID_PERF_EN
        chk("stall_cycles_5", 128'(stall_cycles), 128'd5);
`endif
        stall = 1'b0; out_ready = 1'b0;

        // Flush while full with a same-cycle offer.
        offer(8'd6, 64'h66, 2'b11);
        flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 128'(out_valid), 128'd0);
        chk("flush_pc", 128'(out_pc), 128'd0);
        chk("flush_instr", 128'(out_instr), 128'd0);
        chk("flush_in_ready", 128'(in_ready), 128'd1);
        out_ready = 1'b1; tick(); tick();
        chk("flush_nothing_left", 128'(out_valid), 128'd0);
`ifdef IF_ID_PERF_EN
        chk("flush_count_1", 128'(flush_count), 128'd1);
`endif

        // Lane bubble, then an all-bubble bundle that must be dropped.
        out_ready = 1'b0;
        offer(8'd7, 64'h0000DEAD_00000001, 2'b01); tick();
        chk("bubble_instr", 128'(out_instr), 128'h00000000_00000001);
        chk("bubble_lv", 128'(out_lv), 128'd1);
        offer(8'h55, 64'h12345678_9ABCDEF0, 2'b00); tick();
        chk("empty_drop_pc", 128'(out_pc), 128'd7);
        chk("empty_drop_ready", 128'(in_ready), 128'd1);

        // Reset while full with a simultaneous push.
        offer(8'd8, 64'h00000002_00000003, 2'b11); tick();
        chk("pre_reset_full", 128'(in_ready), 128'd0);
        offer(8'd9, 64'h99, 2'b11);
        reset = 1'b1; tick();
        reset = 1'b0; in_valid = 1'b0;
        chk("reset_valid", 128'(out_valid), 128'd0);
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        chk("reset_instr", 128'(out_instr), 128'd0);
        chk("reset_lv", 128'(out_lv), 128'd0);
`ifdef IF_ID_PERF_EN
        chk("reset_counters", 128'({stall_cycles, flush_count}), 128'd0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_pc     = PC_W'($urandom);
            in_lv     = LANES'($urandom);
            for (int k = 0; k < LANES; k++) in_instr[k*INSTR_W +: INSTR_W] = INSTR_W'($urandom);
            flush     = ($urandom_range(0, 99) < 3);
            stall     = ($urandom_range(0, 9) < 2);
            out_ready = ($urandom_range(0, 9) < 6);
            reset     = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_stage_reg.md
Name: if_id_stage_reg

Overview:
Parametrised instruction-fetch/decode pipeline boundary register. It carries LANES instruction slots, a bundle PC and per-lane valid bits.
- Upstream: fetch unit. Downstream: decoder.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is registered and does not depend combinationally on out_ready.
- Adds per-lane bubbles, synchronous flush and stall on top of the basic stall/flush register.

Parameters:
LANES, 2, instruction slots per bundle (1..4)
INSTR_W, 32, instruction width in bits
PC_W, 8, program counter width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  fetch offers a bundle
in_ready  output  1  stage can accept a bundle; registered
in_pc  input  PC_W  PC of lane 0
in_instr  input  LANES*INSTR_W  lane k at bits [k*INSTR_W +: INSTR_W]
in_lane_valid  input  LANES  per-lane valid
flush  input  1  discard all held and incoming bundles
stall  input  1  decoder hold; blocks dequeue
out_valid  output  1  bundle presented to decoder
out_ready  input  1  decoder accepts
out_pc  output  PC_W  PC of lane 0 of presented bundle
out_instr  output  LANES*INSTR_W  presented instructions
out_lane_valid  output  LANES  per-lane valid of presented bundle

Behaviour:
- Storage: main entry (drives outputs) plus skid entry. Each entry holds pc, instr, lane_valid and a valid flag.
- Events:
  - push = in_valid & in_ready & (|in_lane_valid).
  - pop = out_valid & out_ready & ~stall.
- in_valid=1 with in_lane_valid=0: treated as an empty bundle and dropped. Not stored, no state change.
- in_ready = ~skid_valid. It is a direct flop/state decode, with no combinational path from any input.
- out_valid = main_valid. out_pc, out_instr and out_lane_valid are all-zero whenever main_valid=0.
- Lane masking: an instruction slot whose lane_valid bit is 0 is stored as zero, giving a NOP bubble per lane.
- State machine (encoded by main_valid/skid_valid):
  - EMPTY:
    - push -> ONE; main <= in.
  - ONE:
    - push & ~pop -> FULL; skid <= in.
    - pop & ~push -> EMPTY.
    - push & pop -> ONE; main <= in.
    - neither -> hold.
  - FULL (in_ready=0, so no push):
    - pop -> ONE; main <= skid.
    - else hold.
- Latency: 1 cycle from accepted push to out_valid when EMPTY. Throughput is 1 bundle/cycle in steady state.
- stall=1: no pop regardless of out_ready, and outputs hold stable. Pushes still fill the skid until FULL.
- flush=1: at the next edge both entries are invalidated and all stored fields are zeroed (-> EMPTY). Flush has priority over push and pop, and the same-cycle input bundle is discarded. in_ready=1 the cycle after.
- flush and stall asserted together: flush wins.
- reset=1: identical to flush. It also forces in_ready=1, out_valid=0 and all outputs zero on the cycle after the edge. Reset mid-transfer loses held bundles.
- Ordering: bundles leave in acceptance order. Nothing is duplicated or lost except on flush/reset.

Optional Feature:
Macro IF_ID_PERF_EN.
- Defined: adds outputs stall_cycles (16-bit) and flush_count (16-bit).
  - stall_cycles increments each cycle with out_valid & stall.
  - flush_count increments each cycle flush=1.
  - Both saturate at 16'hFFFF and clear on reset; flush does not clear them.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

Test Plan:
- Reset then single bundle (LANES=2): pc=8'h10, instr={32'hB,32'hA}, lane_valid=2'b11 -> next cycle out_valid=1, out_pc=8'h10, out_instr={B,A}; popped with out_ready=1 -> EMPTY.
- Backpressure: out_ready=0, push 3 bundles PC 1,2,3 -> PC1 and PC2 accepted, in_ready=0 after 2nd push. Release out_ready -> outputs PC1, PC2, PC3 in order with no loss.
- Stall: stall=1 with out_ready=1 while FULL -> outputs frozen for 5 cycles. With IF_ID_PERF_EN, stall_cycles=5.
- Flush mid-FULL with in_valid=1 -> next cycle out_valid=0, all outputs zero, in_ready=1; none of the 3 bundles ever appears.
- Lane bubble: lane_valid=2'b01, instr={32'hDEAD,32'h1} -> out_instr={32'h0,32'h1}, out_lane_valid=2'b01. Then lane_valid=2'b00 with in_valid=1 -> dropped, state unchanged.
- Reset mid-FULL plus simultaneous push -> EMPTY, outputs zero, in_ready=1 the following cycle.
